cmp_window_stats: RTL
=====================

Name: cmp_window_stats

Overview:
- Consumes the per-sample result flags (greater/equal/less) of the 4-bit magnitude comparator and accumulates them over fixed windows of WINDOW accepted samples.
- Emits one statistics record per window through a valid/ready output buffer.
- Sits directly downstream of the comparator, between it and the control/telemetry logic.
- Flags are sampled under a valid/ready input handshake. The block backpressures only when a completed record cannot be stored.

Parameters:
- WINDOW, 16, samples per window (>= 2).
- CNT_W, 5, width of every count field. Must satisfy 2^CNT_W > WINDOW.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  comparator flags valid this cycle.
- in_ready  output  1  block can accept a sample.
- greater  input  1  comparator A>B flag.
- equal  input  1  comparator A==B flag.
- less  input  1  comparator A<B flag.
- out_valid  output  1  record valid.
- out_ready  input  1  consumer accepts record.
- gt_count  output  CNT_W  greater samples in window.
- eq_count  output  CNT_W  equal samples in window.
- lt_count  output  CNT_W  less samples in window.
- err_count  output  CNT_W  non-one-hot samples in window.
- max_gt_run  output  CNT_W  longest run of consecutive greater samples in window.
- dominant  output  2  01=greater, 10=less, 11=equal, 00=tie.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state:
  - out_valid=0, all record outputs 0, in_ready=0.
  - Internal accumulators, sample index, current run and max run all 0.
  - in_ready rises in the first cycle after rst_n deasserts.
- Reset mid-window or mid-hold: the partial window and any pending record are discarded. No record is emitted.
- Accept: a sample is taken when in_valid && in_ready.
- Legal sample: exactly one of greater/equal/less is high. Increment the matching accumulator.
- Illegal sample: zero or more than one flag high. Increment err accumulator only. It still counts toward WINDOW.
- Run tracking:
  - A legal greater sample increments cur_run; max_run = max(max_run, cur_run+1).
  - Any other sample (including illegal) clears cur_run to 0.
- Sample index counts 0..WINDOW-1 and wraps on the completing sample.
- Window completion: the accepted sample with index WINDOW-1 completes the window. On that same edge:
  - Load the output record with the final counts, including this sample.
  - Compute dominant from the loaded counts.
  - Set out_valid=1.
  - Clear accumulators, cur_run, max_run and index.
  - Latency: record visible 1 cycle after the completing sample is accepted.
- dominant encoding:
  - 01 if gt > eq and gt > lt.
  - 10 if lt > gt and lt > eq.
  - 11 if eq > gt and eq > lt.
  - 00 otherwise; err_count is ignored.
- Output handshake:
  - out_valid && out_ready retires the record. out_valid drops next cycle unless a new record loads on the same edge.
  - Record fields hold stable while out_valid=1 and out_ready=0.
  - Record fields keep their last values after retire.
- Backpressure: in_ready = !(index==WINDOW-1 && out_valid && !out_ready).
  - Only the completing sample stalls.
  - This is a combinational path from out_ready to in_ready.
- Simultaneous retire and completion: old record retires, new record loads on the same edge, out_valid stays 1. No bubble, no loss.
- in_valid with in_ready=0: the sample is not accepted and state is unchanged. The upstream stage holds the flags.
- Counts never wrap: the CNT_W rule guarantees WINDOW fits.

Test Plan:
- Bench parameters: WINDOW=4, CNT_W=3.
- Reset: assert rst_n=0 mid-window after 2 samples, release -> out_valid=0, all fields 0. The next 4 samples produce a record counting only those 4.
- Mixed window: flags G,G,E,L with out_ready=1 -> one cycle after the 4th accept: gt=2, eq=1, lt=1, err=0, max_gt_run=2, dominant=01.
- Illegal flags: samples 000, 110, L, L -> err=2, lt=2, gt=0, eq=0, max_gt_run=0, dominant=10.
- Run break: G,E,G,G then G,G,G,L -> records max_gt_run=2, then 3. Runs do not carry across the window boundary.
- Backpressure: out_ready=0 while a second window reaches index 3 -> in_ready=0 only at that point. First record held stable. Raise out_ready -> same-edge retire/load, out_valid stays 1, second record correct.
- Tie: G,G,L,L -> dominant=00; E,E,E,G -> dominant=11, eq=3.

Source files
------------

// File: rtl/cmp_window_stats.sv
// Accumulates comparator result flags over windows of WINDOW accepted samples and
// emits one statistics record per window through a valid/ready output buffer.
module cmp_window_stats #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             greater,
  input  logic             equal,
  input  logic             less,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] max_gt_run,
  output logic [1:0]       dominant
);

  localparam int unsigned      IDX_W = $clog2(WINDOW);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(WINDOW - 1);

  logic             r_en;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_gt, r_eq, r_lt, r_err, r_cur_run, r_max_run;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_gt_o, r_eq_o, r_lt_o, r_err_o, r_run_o;
  logic [1:0]       r_dom_o;

  logic             w_legal, w_g, w_last, w_accept, w_retire;
  logic [CNT_W-1:0] w_gt_nx, w_eq_nx, w_lt_nx, w_err_nx, w_run_inc, w_max_nx;
  logic [1:0]       w_dom_nx;

  // One-hot of three: odd parity and not all three set.
  assign w_legal  = (greater ^ equal ^ less) && !(greater && equal && less);
  assign w_g      = w_legal && greater;
  assign w_last   = (r_idx == LAST);
  // r_en keeps in_ready low until the first edge after reset release.
  assign in_ready = r_en && !(w_last && r_out_valid && !out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_retire = r_out_valid && out_ready;

  always_comb begin
    w_gt_nx   = r_gt + CNT_W'(w_g);
    w_eq_nx   = r_eq + CNT_W'(w_legal && equal);
    w_lt_nx   = r_lt + CNT_W'(w_legal && less);
    w_err_nx  = r_err + CNT_W'(!w_legal);
    w_run_inc = r_cur_run + CNT_W'(1);
    w_max_nx  = r_max_run;
    if (w_g && (w_run_inc > r_max_run)) begin
      w_max_nx = w_run_inc;
    end
    w_dom_nx = 2'b00;
    if ((w_gt_nx > w_eq_nx) && (w_gt_nx > w_lt_nx)) begin
      w_dom_nx = 2'b01;
    end else if ((w_lt_nx > w_gt_nx) && (w_lt_nx > w_eq_nx)) begin
      w_dom_nx = 2'b10;
    end else if ((w_eq_nx > w_gt_nx) && (w_eq_nx > w_lt_nx)) begin
      w_dom_nx = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en        <= 1'b0;
      r_idx       <= '0;
      r_gt        <= '0;
      r_eq        <= '0;
      r_lt        <= '0;
      r_err       <= '0;
      r_cur_run   <= '0;
      r_max_run   <= '0;
      r_out_valid <= 1'b0;
      r_gt_o      <= '0;
      r_eq_o      <= '0;
      r_lt_o      <= '0;
      r_err_o     <= '0;
      r_run_o     <= '0;
      r_dom_o     <= 2'b00;
    end else begin
      r_en <= 1'b1;
      if (w_accept && w_last) begin
        r_gt_o      <= w_gt_nx;
        r_eq_o      <= w_eq_nx;
        r_lt_o      <= w_lt_nx;
        r_err_o     <= w_err_nx;
        r_run_o     <= w_max_nx;
        r_dom_o     <= w_dom_nx;
        r_out_valid <= 1'b1;
        r_idx       <= '0;
        r_gt        <= '0;
        r_eq        <= '0;
        r_lt        <= '0;
        r_err       <= '0;
        r_cur_run   <= '0;
        r_max_run   <= '0;
      end else begin
        if (w_retire) begin
          r_out_valid <= 1'b0;
        end
        if (w_accept) begin
          r_idx     <= r_idx + IDX_W'(1);
          r_gt      <= w_gt_nx;
          r_eq      <= w_eq_nx;
          r_lt      <= w_lt_nx;
          r_err     <= w_err_nx;
          r_cur_run <= w_g ? w_run_inc : '0;
          r_max_run <= w_max_nx;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign gt_count   = r_gt_o;
  assign eq_count   = r_eq_o;
  assign lt_count   = r_lt_o;
  assign err_count  = r_err_o;
  assign max_gt_run = r_run_o;
  assign dominant   = r_dom_o;

endmodule
